// File: rtl/rr_handshake_responder_if.sv
// Bundle between the three-lane handshake producers, the responder and its downstream consumer.
// The master side drives lane beats and downstream ready; the slave side is the responder.
interface rr_handshake_responder_if #(
  parameter int WIDTH     = 5,
  parameter int CNT_WIDTH = 16
);
  logic             handshake_arr_0_valid;
  logic [WIDTH-1:0] handshake_arr_0_data;
  logic             handshake_arr_0_ready;
  logic             handshake_arr_1_valid;
  logic [WIDTH-1:0] handshake_arr_1_data;
  logic             handshake_arr_1_ready;
  logic             handshake_arr_2_valid;
  logic [WIDTH-1:0] handshake_arr_2_data;
  logic             handshake_arr_2_ready;

  logic                 handshake_valid;
  logic                 handshake_ready;
  logic [WIDTH-1:0]     out_data;
  logic [1:0]           out_lane;
  logic                 out_orr;
  logic                 out_andr;
  logic [CNT_WIDTH-1:0] accept_count;

  modport master (
    output handshake_arr_0_valid, handshake_arr_0_data,
    output handshake_arr_1_valid, handshake_arr_1_data,
    output handshake_arr_2_valid, handshake_arr_2_data,
    input  handshake_arr_0_ready, handshake_arr_1_ready, handshake_arr_2_ready,
    output handshake_ready,
    input  handshake_valid, out_data, out_lane, out_orr, out_andr, accept_count
  );

  modport slave (
    input  handshake_arr_0_valid, handshake_arr_0_data,
    input  handshake_arr_1_valid, handshake_arr_1_data,
    input  handshake_arr_2_valid, handshake_arr_2_data,
    output handshake_arr_0_ready, handshake_arr_1_ready, handshake_arr_2_ready,
    input  handshake_ready,
    output handshake_valid, out_data, out_lane, out_orr, out_andr, accept_count
  );
endinterface

// File: rtl/rr_handshake_responder.sv
// Round-robin consumer of three ready/valid lanes; accepted beats plus their OR/AND
// reductions are queued in a DEPTH-entry FIFO and replayed on one downstream port.
module rr_lane_port (
  input  logic granted,
  input  logic space,
  input  logic rst,
  input  logic valid,
  output logic ready,
  output logic accept
);
  assign ready  = granted & space & ~rst;
  assign accept = valid & ready;
endmodule

module rr_handshake_responder #(
  parameter int WIDTH     = 5,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic CLK,
  input  logic RESET,
  rr_handshake_responder_if.slave bus
);
  localparam int NUM_LANES = 3;
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW        = AW + 1;

  typedef struct packed {
    logic [1:0]       lane;
    logic [WIDTH-1:0] data;
    logic             orr;
    logic             andr;
  } entry_t;

  logic [NUM_LANES-1:0]            lane_vld, lane_rdy, lane_acc, gnt_oh;
  logic [NUM_LANES-1:0][WIDTH-1:0] lane_data;

  logic [1:0]           ptr, gnt;
  logic                 gnt_vld;
  logic [2:0]           cand;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [CNT_WIDTH-1:0] acc_cnt;
  logic                 full, push, pop;
  entry_t               mem [DEPTH];
  entry_t               push_e, head;

  assign lane_vld  = {bus.handshake_arr_2_valid, bus.handshake_arr_1_valid, bus.handshake_arr_0_valid};
  assign lane_data = {bus.handshake_arr_2_data,  bus.handshake_arr_1_data,  bus.handshake_arr_0_data};
  assign bus.handshake_arr_0_ready = lane_rdy[0];
  assign bus.handshake_arr_1_ready = lane_rdy[1];
  assign bus.handshake_arr_2_ready = lane_rdy[2];

  // Search ptr, ptr+1, ptr+2 (mod 3); first valid lane wins.
  always_comb begin
    gnt     = 2'd0;
    gnt_vld = 1'b0;
    cand    = 3'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cand = {1'b0, ptr} + 3'(i);
      if (cand >= 3'(NUM_LANES)) cand = cand - 3'(NUM_LANES);
      if (!gnt_vld && lane_vld[cand[1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = cand[1:0];
      end
    end
  end

  assign full = (count == CW'(DEPTH));

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    assign gnt_oh[n] = gnt_vld && (gnt == 2'(n));
    rr_lane_port u_lane (
      .granted (gnt_oh[n]),
      .space   (~full),
      .rst     (RESET),
      .valid   (lane_vld[n]),
      .ready   (lane_rdy[n]),
      .accept  (lane_acc[n])
    );
  end

  assign push        = |lane_acc;
  assign pop         = (count != '0) && bus.handshake_ready;
  assign push_e.lane = gnt;
  assign push_e.data = lane_data[gnt];
  assign push_e.orr  = |lane_data[gnt];
  assign push_e.andr = &lane_data[gnt];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr     <= 2'd0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      acc_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_e;
        wr_ptr      <= wr_ptr + AW'(1);
        ptr         <= (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
        acc_cnt     <= acc_cnt + CNT_WIDTH'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head is read straight from storage, so nothing on the lane side reaches the outputs.
  assign head                = mem[rd_ptr];
  assign bus.handshake_valid = (count != '0);
  assign bus.out_data        = head.data;
  assign bus.out_lane        = head.lane;
  assign bus.out_orr         = head.orr;
  assign bus.out_andr        = head.andr;
  assign bus.accept_count    = acc_cnt;
endmodule

// File: tb/tb_rr_handshake_responder.sv
// Directed scoreboard bench: stimulus queues expected {lane,data,orr,andr} words,
// a negedge monitor pops and compares on every downstream handshake.
module tb_rr_handshake_responder;
  localparam int WIDTH = 5, DEPTH = 4, CNT_WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_handshake_responder_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus();

  rr_handshake_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_got, mon_exp;
  logic [2:0] rdy;
  logic [8:0] head;

  assign rdy  = {bus.handshake_arr_2_ready, bus.handshake_arr_1_ready, bus.handshake_arr_0_ready};
  assign head = {bus.out_lane, bus.out_data, bus.out_orr, bus.out_andr};

  function automatic logic [8:0] ent(input logic [1:0] lane, input logic [4:0] d,
                                     input logic o, input logic a);
    return {lane, d, o, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lanes(input logic [2:0] v, input logic [4:0] d0, input logic [4:0] d1,
                       input logic [4:0] d2);
    bus.handshake_arr_0_valid = v[0];
    bus.handshake_arr_1_valid = v[1];
    bus.handshake_arr_2_valid = v[2];
    bus.handshake_arr_0_data  = d0;
    bus.handshake_arr_1_data  = d1;
    bus.handshake_arr_2_data  = d2;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.handshake_valid === 1'b1 && bus.handshake_ready === 1'b1) begin
      mon_got = head;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got %0h expected no beat", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_err++;
          $display("FAIL pop_order: got %0h expected %0h", mon_got, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] t3_d [4];
    logic       t3_o [4];
    logic       t3_a [4];
    t3_d = '{5'h00, 5'h01, 5'h1F, 5'h10};
    t3_o = '{1'b0, 1'b1, 1'b1, 1'b1};
    t3_a = '{1'b0, 1'b0, 1'b1, 1'b0};

    // Reset with every lane offering: no ready may rise.
    lanes(3'b111, 5'h1F, 5'h1F, 5'h1F);
    bus.handshake_ready = 1'b1;
    step();
    @(negedge clk);
    chk("rst_ready", 32'(rdy), 32'h0);
    chk("rst_valid", 32'(bus.handshake_valid), 32'h0);
    chk("rst_head", 32'(head), 32'h0);
    chk("rst_count", 32'(bus.accept_count), 32'h0);
    step();
    rst = 1'b0;

    // All lanes valid: grants rotate 0,1,2,0,1,2.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t1_ready", 32'(rdy), 32'(1 << (i % 3)));
      exp_q.push_back(ent(2'(i % 3), 5'h1F, 1'b1, 1'b1));
      step();
    end
    chk("t1_accept_count", 32'(bus.accept_count), 32'd6);
    lanes(3'b000, 5'h0, 5'h0, 5'h0);
    step();
    chk("t1_drain", 32'(bus.handshake_valid), 32'h0);

    // Lanes 0 and 2 contend, lane 1 idle.
    lanes(3'b101, 5'h05, 5'h00, 5'h0A);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_ready", 32'(rdy), (i % 2) ? 32'h4 : 32'h1);
      exp_q.push_back((i % 2) ? ent(2'd2, 5'h0A, 1'b1, 1'b0) : ent(2'd0, 5'h05, 1'b1, 1'b0));
      step();
    end
    lanes(3'b000, 5'h0, 5'h0, 5'h0);
    step();
    chk("t2_drain", 32'(bus.handshake_valid), 32'h0);

    // Backpressure fills the FIFO from lane 0.
    bus.handshake_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lanes(3'b001, t3_d[i], 5'h0, 5'h0);
      @(negedge clk);
      chk("t3_ready", 32'(rdy), 32'h1);
      exp_q.push_back(ent(2'd0, t3_d[i], t3_o[i], t3_a[i]));
      step();
    end
    lanes(3'b001, 5'h07, 5'h0, 5'h0);
    @(negedge clk);
    chk("t3_full_ready", 32'(rdy), 32'h0);
    chk("t3_full_valid", 32'(bus.handshake_valid), 32'h1);
    chk("t3_accept_count", 32'(bus.accept_count), 32'd14);
    step();
    @(negedge clk);
    chk("t3_full_ready2", 32'(rdy), 32'h0);
    chk("t3_head_stable", 32'(head), 32'(ent(2'd0, 5'h00, 1'b0, 1'b0)));
    step();
    lanes(3'b000, 5'h0, 5'h0, 5'h0);
    bus.handshake_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t3_drain", 32'(bus.handshake_valid), 32'h0);

    // Prime count=2 on lane 1, then push and pop together for 10 cycles.
    bus.handshake_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      lanes(3'b010, 5'h0, 5'(2 + i), 5'h0);
      @(negedge clk);
      chk("t4_prime_ready", 32'(rdy), 32'h2);
      exp_q.push_back(ent(2'd1, 5'(2 + i), 1'b1, 1'b0));
      step();
    end
    chk("t4_count_before", 32'(bus.accept_count), 32'd16);
    bus.handshake_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      lanes(3'b010, 5'h0, 5'(4 + i), 5'h0);
      @(negedge clk);
      chk("t4_ready", 32'(rdy), 32'h2);
      chk("t4_valid", 32'(bus.handshake_valid), 32'h1);
      exp_q.push_back(ent(2'd1, 5'(4 + i), 1'b1, 1'b0));
      step();
    end
    chk("t4_count_after", 32'(bus.accept_count), 32'd26);
    lanes(3'b000, 5'h0, 5'h0, 5'h0);
    step();
    chk("t4_occ_one", 32'(bus.handshake_valid), 32'h1);
    step();
    chk("t4_occ_zero", 32'(bus.handshake_valid), 32'h0);

    // Full boundary on lane 2: a pop while full still blocks the accept.
    bus.handshake_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lanes(3'b100, 5'h0, 5'h0, 5'(5'h11 + i));
      @(negedge clk);
      chk("t5_fill_ready", 32'(rdy), 32'h4);
      exp_q.push_back(ent(2'd2, 5'(5'h11 + i), 1'b1, 1'b0));
      step();
    end
    bus.handshake_ready = 1'b1;
    lanes(3'b100, 5'h0, 5'h0, 5'h15);
    @(negedge clk);
    chk("t5_full_pop_ready", 32'(rdy), 32'h0);
    chk("t5_full_valid", 32'(bus.handshake_valid), 32'h1);
    step();
    bus.handshake_ready = 1'b0;
    @(negedge clk);
    chk("t5_refill_ready", 32'(rdy), 32'h4);
    exp_q.push_back(ent(2'd2, 5'h15, 1'b1, 1'b0));
    step();
    @(negedge clk);
    chk("t5_full_again", 32'(rdy), 32'h0);
    chk("t5_accept_count", 32'(bus.accept_count), 32'd31);
    step();
    lanes(3'b000, 5'h0, 5'h0, 5'h0);
    bus.handshake_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t5_drain", 32'(bus.handshake_valid), 32'h0);

    // Fresh reset, build count=3 / accept_count=7, then reset mid-flight.
    rst = 1'b1;
    step();
    rst = 1'b0;
    lanes(3'b111, 5'h1F, 5'h1F, 5'h1F);
    for (int i = 0; i < 7; i++) begin
      bus.handshake_ready = (i < 5);
      @(negedge clk);
      chk("t6_ready", 32'(rdy), 32'(1 << (i % 3)));
      exp_q.push_back(ent(2'(i % 3), 5'h1F, 1'b1, 1'b1));
      step();
    end
    chk("t6_pre_count", 32'(bus.accept_count), 32'd7);
    chk("t6_pre_valid", 32'(bus.handshake_valid), 32'h1);
    rst = 1'b1;
    bus.handshake_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t6_rst_ready", 32'(rdy), 32'h0);
    step();
    rst = 1'b0;
    chk("t6_post_valid", 32'(bus.handshake_valid), 32'h0);
    chk("t6_post_head", 32'(head), 32'h0);
    chk("t6_post_count", 32'(bus.accept_count), 32'h0);
    @(negedge clk);
    chk("t6_first_grant", 32'(rdy), 32'h1);
    exp_q.push_back(ent(2'd0, 5'h1F, 1'b1, 1'b1));
    step();
    lanes(3'b000, 5'h0, 5'h0, 5'h0);
    bus.handshake_ready = 1'b1;
    step();
    chk("t6_drain", 32'(bus.handshake_valid), 32'h0);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
